// File: rtl/resp_queue.sv
// Multi-source response byte queue feeding UART_tx: per-source capture slots, lowest-index
// arbitration into a FIFO, and a 3-state transmit handshake. RESP_OVF_CNT_EN adds ovf_cnt.

module resp_src_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  input  logic [DATA_W-1:0] code,
  input  logic              enq,
  output logic              pend,
  output logic [DATA_W-1:0] code_q,
  output logic              drop
);
  // A request is only refused when the slot is still occupied and not draining this cycle.
  assign drop = req && pend && !enq && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= 1'b0;
      code_q <= '0;
    end else if (clr) begin
      pend   <= 1'b0;
    end else if (req && (!pend || enq)) begin
      pend   <= 1'b1;
      code_q <= code;
    end else if (enq) begin
      pend   <= 1'b0;
    end
  end
endmodule

module resp_queue #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*DATA_W-1:0] src_code,
  output logic                      trmt,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      empty,
  output logic                      full,
  output logic                      ovf
`ifdef RESP_OVF_CNT_EN
  ,
  output logic [7:0]                ovf_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

  logic [NUM_SRC-1:0]             pend, enq_sel, low, drop;
  logic [NUM_SRC-1:0][DATA_W-1:0] codes;
  logic [DATA_W-1:0]              wr_data;
  logic [AW:0]                    wr_ptr, rd_ptr, count;
  logic [DATA_W-1:0]              mem [DEPTH];
  logic                           push, pop;
  state_t                         state_q, state_d;
  logic                           trmt_d;
  logic [DATA_W-1:0]              tx_data_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    resp_src_slot #(.DATA_W(DATA_W)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .req    (src_req[i]),
      .code   (src_code[i*DATA_W +: DATA_W]),
      .enq    (enq_sel[i]),
      .pend   (pend[i]),
      .code_q (codes[i]),
      .drop   (drop[i])
    );
  end

  // Two's-complement trick isolates the lowest pending source.
  assign low     = pend & (~pend + 1'b1);
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = (|pend) && (!full || pop);
  assign enq_sel = push ? low : '0;
  assign busy    = (state_q != IDLE);

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (low[i]) wr_data = codes[i];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    trmt_d    = 1'b0;
    tx_data_d = tx_data;
    pop       = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        tx_data_d = mem[rd_ptr[AW-1:0]];
        trmt_d    = 1'b1;
        state_d   = LOAD;
      end
      LOAD:      state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // tx_data survives clr so a byte already handed to the UART stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      trmt    <= 1'b0;
      tx_data <= '0;
    end else if (clr) begin
      state_q <= IDLE;
      trmt    <= 1'b0;
    end else begin
      state_q <= state_d;
      trmt    <= trmt_d;
      tx_data <= tx_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ovf <= 1'b0;
    else if (|drop) ovf <= 1'b1;
  end

`ifdef RESP_OVF_CNT_EN
  logic [7:0] drop_n;
  logic [8:0] cnt_sum;

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_SRC; i++) drop_n = drop_n + 8'(drop[i]);
  end

  assign cnt_sum = {1'b0, ovf_cnt} + {1'b0, drop_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt <= '0;
    else     ovf_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end
`endif
endmodule

// File: tb/tb_resp_queue.sv
// Scoreboard bench for resp_queue: expected bytes queued at request time, checked on trmt.
// Build with +define+RESP_OVF_CNT_EN to also check ovf_cnt.

module tb_resp_queue;
  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 8;
  localparam int DATA_W  = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      clr = 1'b0;
  logic [NUM_SRC-1:0]        src_req = '0;
  logic [NUM_SRC*DATA_W-1:0] src_code = '0;
  logic                      trmt, busy, empty, full, ovf;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done = 1'b0;
`ifdef RESP_OVF_CNT_EN
  logic [7:0]                ovf_cnt;
`endif

  int          checks = 0;
  int          passes = 0;
  int          trmt_cnt = 0;
  bit          auto_done = 1'b0;
  logic [7:0]  sb[$];

  resp_queue #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .src_req  (src_req),
    .src_code (src_code),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .empty    (empty),
    .full     (full),
    .ovf      (ovf)
`ifdef RESP_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Every transmitted byte must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (trmt) begin
      trmt_cnt++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL trmt_unexpected: tx_data %h, expected no transmission", tx_data);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (tx_data !== exp) $display("FAIL tx_byte: got %h expected %h", tx_data, exp);
        else passes++;
      end
    end
  end

  // UART stand-in: completes a byte a few cycles after trmt when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_done && trmt) begin
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic post(input int s, input logic [7:0] c);
    @(negedge clk);
    src_code[s*DATA_W +: DATA_W] = c;
    src_req = '0;
    src_req[s] = 1'b1;
    @(negedge clk);
    src_req = '0;
  endtask

  task automatic wait_trmt(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (trmt) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL %s: trmt not seen within 100 cycles", name);
    else passes++;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && empty && !trmt) done = 1'b1;
    end
    checks++;
    if (!done) $display("FAIL %s: drain timeout, %0d bytes outstanding", name, sb.size());
    else passes++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({trmt, busy, empty, full, ovf, tx_data} !== {5'b00100, 8'h00})
      $display("FAIL reset_state: got trmt%b busy%b empty%b full%b ovf%b data%h, expected 0 0 1 0 0 00",
               trmt, busy, empty, full, ovf, tx_data);
    else passes++;
`ifdef RESP_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 8'h00) $display("FAIL reset_ovf_cnt: got %h expected 00", ovf_cnt);
    else passes++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    auto_done = 1'b0;
    @(negedge clk);
    src_code[7:0] = 8'hA5;
    src_req = 4'b0001;
    sb.push_back(8'hA5);
    @(negedge clk);
    src_req = '0;
    checks++;
    if (trmt !== 1'b0) $display("FAIL single_lat1: trmt %b expected 0", trmt); else passes++;
    @(negedge clk);
    checks++;
    if (trmt !== 1'b0 || empty !== 1'b0)
      $display("FAIL single_lat2: trmt %b empty %b expected 0 0", trmt, empty);
    else passes++;
    @(negedge clk);
    checks++;
    if (trmt !== 1'b1 || busy !== 1'b1 || tx_data !== 8'hA5)
      $display("FAIL single_lat3: trmt %b busy %b data %h expected 1 1 a5", trmt, busy, tx_data);
    else passes++;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || trmt !== 1'b0)
      $display("FAIL single_wait: busy %b trmt %b expected 1 0", busy, trmt);
    else passes++;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'hA5)
      $display("FAIL single_done: busy %b data %h expected 0 a5", busy, tx_data);
    else passes++;
  endtask

  task automatic test_simultaneous();
    auto_done = 1'b1;
    @(negedge clk);
    src_code[0*8 +: 8] = 8'h5A;
    src_code[2*8 +: 8] = 8'hA5;
    src_code[3*8 +: 8] = 8'h11;
    src_req = 4'b1101;
    sb.push_back(8'h5A);
    sb.push_back(8'hA5);
    sb.push_back(8'h11);
    @(negedge clk);
    src_req = '0;
    wait_idle("simul_drain");
    checks++;
    if (ovf !== 1'b0) $display("FAIL simul_ovf: got %b expected 0", ovf); else passes++;
  endtask

  task automatic test_overflow();
    int base;
    auto_done = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      @(negedge clk);
      src_code[15:8] = 8'(8'h30 + k);
      src_req = 4'b0010;
      if (k < DEPTH + 2) sb.push_back(8'(8'h30 + k));
    end
    @(negedge clk);
    src_req = '0;
    checks++;
    if (full !== 1'b1 || ovf !== 1'b1 || busy !== 1'b1)
      $display("FAIL ovf_full: full %b ovf %b busy %b expected 1 1 1", full, ovf, busy);
    else passes++;
`ifdef RESP_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 8'h01) $display("FAIL ovf_cnt: got %h expected 01", ovf_cnt); else passes++;
`endif
    base = trmt_cnt;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    auto_done = 1'b1;
    wait_idle("ovf_drain");
    checks++;
    if (trmt_cnt - base !== DEPTH + 1)
      $display("FAIL ovf_sent: got %0d bytes expected %0d", trmt_cnt - base, DEPTH + 1);
    else passes++;
    checks++;
    if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", ovf); else passes++;
  endtask

  task automatic test_clr();
    int base;
    auto_done = 1'b0;
    @(negedge clk);
    src_code = {8'h44, 8'h43, 8'h42, 8'h41};
    src_req = 4'b1111;
    sb.push_back(8'h41);
    sb.push_back(8'h42);
    sb.push_back(8'h43);
    sb.push_back(8'h44);
    @(negedge clk);
    src_req = '0;
    wait_trmt("clr_first_trmt");
    repeat (3) @(negedge clk);
    checks++;
    if (empty !== 1'b0 || full !== 1'b0 || busy !== 1'b1)
      $display("FAIL clr_pre: empty %b full %b busy %b expected 0 0 1", empty, full, busy);
    else passes++;
    clr = 1'b1;
    sb.delete();
    base = trmt_cnt;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (empty !== 1'b1 || busy !== 1'b0 || trmt !== 1'b0 || tx_data !== 8'h41 || ovf !== 1'b1)
      $display("FAIL clr_post: empty %b busy %b trmt %b data %h ovf %b expected 1 0 0 41 1",
               empty, busy, trmt, tx_data, ovf);
    else passes++;
    repeat (5) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (trmt_cnt !== base) $display("FAIL clr_no_trmt: got %0d trmt expected %0d", trmt_cnt, base);
    else passes++;
  endtask

  task automatic test_rst_mid();
    auto_done = 1'b0;
    sb.push_back(8'h77);
    post(0, 8'h77);
    wait_trmt("rst_first_trmt");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({trmt, busy, empty, full, ovf, tx_data} !== {5'b00100, 8'h00})
      $display("FAIL rst_async: got trmt%b busy%b empty%b full%b ovf%b data%h, expected 0 0 1 0 0 00",
               trmt, busy, empty, full, ovf, tx_data);
    else passes++;
`ifdef RESP_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 8'h00) $display("FAIL rst_ovf_cnt: got %h expected 00", ovf_cnt); else passes++;
`endif
    @(negedge clk);
    rst = 1'b0;
    auto_done = 1'b1;
    sb.push_back(8'hA5);
    post(0, 8'hA5);
    wait_idle("rst_resume");
  endtask

  task automatic test_spurious_done();
    int base;
    auto_done = 1'b0;
    base = trmt_cnt;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || trmt !== 1'b0 || empty !== 1'b1)
        $display("FAIL spurious_done: busy %b trmt %b empty %b expected 0 0 1", busy, trmt, empty);
      else passes++;
    end
    checks++;
    if (trmt_cnt !== base) $display("FAIL spurious_trmt: got %0d expected %0d", trmt_cnt, base);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_clr();
    test_rst_mid();
    test_spurious_done();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
